// File: rtl/replica_pkg.sv
// Shared types and constants for the replica-exchange initiator.
package replica_pkg;

   localparam int TOTAL_W = 16;
   localparam int DBETA   = 8;

   typedef logic [TOTAL_W-1:0] total_data_t;

   typedef enum logic [1:0] {
      NOP  = 2'd0,
      PREV = 2'd1,
      FOLW = 2'd2
   } exchange_command_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TEST  = 2'd1,
      FLUSH = 2'd2,
      APPLY = 2'd3
   } xchg_state_t;

endpackage

// File: rtl/exchange_ctrl_exp.sv
// Combinational exp approximation: x (4 fractional bits, base-2 scaled) -> 23-bit fraction.
// x >= 0 saturates to all ones; each 16 units of -x halve the result.
module exchange_ctrl_exp (
   input  logic signed [31:0] x,
   output logic [22:0]        frac
);

   localparam int FRAC_W = 4;

   logic [31:0]        y;
   logic [31-FRAC_W:0] k;
   logic [FRAC_W-1:0]  f;
   logic [22:0]        mant;

   always_comb begin
      y    = 32'(-x);
      k    = y[31:FRAC_W];
      f    = y[FRAC_W-1:0];
      // linear stand-in for 2^(-f/16) over one octave
      mant = 23'h7FFFFF - {1'b0, f, 18'd0};
      frac = '0;
      if (x >= 0)
         frac = 23'h7FFFFF;
      else if (k < (32-FRAC_W)'(23))
         frac = mant >> k[4:0];
   end

endmodule

// File: rtl/exchange_ctrl.sv
// Replica-exchange initiator: tests adjacent pairs one per cycle through a 2-stage pipe
// and issues one cycle of per-replica exchange commands at the end of each run.
module exchange_ctrl
   import replica_pkg::*;
#(
   parameter int NREP = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   output logic                          busy,
   output logic                          done,
   output logic                          parity,
   input  total_data_t [NREP-1:0]        total_in,
   output logic                          rnd_en,
   input  logic [31:0]                   r_exchange,
   output exchange_command_t [NREP-1:0]  command,
   output logic [31:0]                   accept_cnt
);

   localparam int PW = $clog2(NREP) + 1;
   localparam int DW = TOTAL_W + 1;

   xchg_state_t              state;
   logic [PW-1:0]            pidx;
   logic [PW-1:0]            npair;
   logic [PW-1:0]            j;
   logic                     s1_vld;
   logic [PW-1:0]            s1_j;
   logic signed [31:0]       x_q;
   logic [22:0]              r_q;
   logic [NREP-2:0]          accept;
   logic [NREP-2:0]          acc_next;
   logic [22:0]              exp_frac;
   logic signed [DW-1:0]     diff;
   logic signed [31:0]       x_new;
   logic [PW-1:0]            n_acc;
   logic [32:0]              cnt_sum;
   exchange_command_t [NREP-1:0] cmd_next;
   logic                     unused_rnd;

   assign unused_rnd = ^r_exchange[31:23];

   assign npair = parity ? PW'((NREP-1)/2) : PW'(NREP/2);
   assign j     = (pidx << 1) | PW'(parity);
   assign diff  = $signed({1'b0, total_in[j + PW'(1)]}) - $signed({1'b0, total_in[j]});
   assign x_new = (32'(diff) * DBETA) >>> 3;

   exchange_ctrl_exp u_exp (
      .x    (x_q),
      .frac (exp_frac)
   );

   // Stage 2 result is merged here so FLUSH can build commands from the final pair too.
   always_comb begin
      acc_next = accept;
      if (s1_vld && ((x_q >= 0) || (exp_frac > r_q)))
         acc_next[s1_j] = 1'b1;
   end

   always_comb begin
      n_acc = '0;
      for (int i = 0; i < NREP; i++)
         cmd_next[i] = NOP;
      for (int i = 0; i < NREP-1; i++) begin
         n_acc = n_acc + PW'(acc_next[i]);
         if (acc_next[i]) begin
            cmd_next[i]   = FOLW;
            cmd_next[i+1] = PREV;
         end
      end
   end

   assign cnt_sum = {1'b0, accept_cnt} + 33'(n_acc);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         parity     <= 1'b0;
         rnd_en     <= 1'b0;
         pidx       <= '0;
         s1_vld     <= 1'b0;
         s1_j       <= '0;
         x_q        <= '0;
         r_q        <= '0;
         accept     <= '0;
         accept_cnt <= '0;
         for (int i = 0; i < NREP; i++)
            command[i] <= NOP;
      end else begin
         s1_vld <= 1'b0;
         done   <= 1'b0;
         accept <= acc_next;
         if (rnd_en) begin
            s1_vld <= 1'b1;
            s1_j   <= j;
            x_q    <= x_new;
            r_q    <= r_exchange[22:0];
         end
         case (state)
            IDLE: begin
               if (start) begin
                  busy   <= 1'b1;
                  pidx   <= '0;
                  accept <= '0;
                  if (npair == '0) begin
                     state <= FLUSH;
                  end else begin
                     state  <= TEST;
                     rnd_en <= 1'b1;
                  end
               end
            end
            TEST: begin
               pidx <= pidx + PW'(1);
               if (pidx == npair - PW'(1)) begin
                  state  <= FLUSH;
                  rnd_en <= 1'b0;
               end
            end
            FLUSH: begin
               state      <= APPLY;
               command    <= cmd_next;
               done       <= 1'b1;
               accept_cnt <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
            end
            APPLY: begin
               state  <= IDLE;
               busy   <= 1'b0;
               parity <= ~parity;
               for (int i = 0; i < NREP; i++)
                  command[i] <= NOP;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exchange_ctrl.sv
// Directed bench for exchange_ctrl with NREP=4; expected values worked out by hand.
module tb_exchange_ctrl;
   import replica_pkg::*;

   localparam int NREP = 4;

   logic                          clk = 1'b0;
   logic                          reset;
   logic                          start;
   logic                          busy;
   logic                          done;
   logic                          parity;
   total_data_t [NREP-1:0]        total_in;
   logic                          rnd_en;
   logic [31:0]                   r_exchange;
   exchange_command_t [NREP-1:0]  command;
   logic [31:0]                   accept_cnt;

   int checks = 0;
   int errors = 0;
   int lat, rc, dn, last_done, n_done;
   logic busy_c4;

   always #5 clk = ~clk;

   exchange_ctrl #(.NREP(NREP)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .parity     (parity),
      .total_in   (total_in),
      .rnd_en     (rnd_en),
      .r_exchange (r_exchange),
      .command    (command),
      .accept_cnt (accept_cnt)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_tot(input int a0, input int a1, input int a2, input int a3);
      total_in[0] = TOTAL_W'(a0);
      total_in[1] = TOTAL_W'(a1);
      total_in[2] = TOTAL_W'(a2);
      total_in[3] = TOTAL_W'(a3);
   endtask

   // Pulses start for one edge; returns the cycle done was seen in and the rnd_en cycle count.
   task automatic run(output int l, output int r);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      l = 1;
      r = 0;
      while (!done && l < 20) begin
         if (rnd_en) r++;
         @(negedge clk);
         l++;
      end
   endtask

   task automatic post_run(input string tag, input logic exp_par);
      @(negedge clk);
      check({tag, "_busy_off"}, busy, 0);
      check({tag, "_cmd_nop"}, command, 0);
      check({tag, "_done_off"}, done, 0);
      check({tag, "_parity"}, parity, exp_par);
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      r_exchange = '0;
      set_tot(0, 0, 0, 0);
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_parity", parity, 0);
      check("rst_rnd_en", rnd_en, 0);
      check("rst_cmd", command, 0);
      check("rst_cnt", accept_cnt, 0);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_wins_busy", busy, 0);
      check("rst_wins_rnd", rnd_en, 0);
      start = 1'b0;
      reset = 1'b1;

      // even run: pair (0,1) positive, pair (2,3) equal
      set_tot(100, 200, 150, 150);
      r_exchange = 32'h0055_AA33;
      run(lat, rc);
      check("t1_lat", lat, 4);
      check("t1_cmd", command, 8'h66);
      check("t1_cnt", accept_cnt, 2);
      check("t1_rnd", rc, 2);
      check("t1_busy", busy, 1);
      post_run("t1", 1'b1);

      // odd run, negative x against max random word
      set_tot(0, 500, 100, 0);
      r_exchange = 32'hFF7F_FFFF;
      run(lat, rc);
      check("t2_lat", lat, 3);
      check("t2_cmd", command, 0);
      check("t2_cnt", accept_cnt, 2);
      check("t2_rnd", rc, 1);
      post_run("t2", 1'b0);

      set_tot(0, 100, 900, 0);
      r_exchange = 32'h0;
      run(lat, rc);
      check("t3a_lat", lat, 4);
      check("t3a_cmd", command, 8'h06);
      check("t3a_cnt", accept_cnt, 3);
      post_run("t3a", 1'b1);

      run(lat, rc);
      check("t3_lat", lat, 3);
      check("t3_cmd", command, 8'h18);
      check("t3_cnt", accept_cnt, 4);
      post_run("t3", 1'b0);

      // reset in cycle 2 of a run
      set_tot(100, 200, 150, 150);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("t4_busy", busy, 0);
      check("t4_cmd", command, 0);
      check("t4_rnd", rnd_en, 0);
      check("t4_cnt", accept_cnt, 0);
      reset = 1'b1;
      n_done = 0;
      repeat (6) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check("t4_no_done", n_done, 0);
      run(lat, rc);
      check("t4_lat", lat, 4);
      check("t4_cmd_after", command, 8'h66);
      check("t4_cnt_after", accept_cnt, 2);
      post_run("t4", 1'b1);

      // start held high: odd, even, odd runs back to back
      r_exchange = 32'h0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      dn = 0;
      rc = 0;
      last_done = 0;
      busy_c4 = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (done) begin
            dn++;
            last_done = c;
         end
         if (rnd_en) rc++;
         if (c == 4) busy_c4 = busy;
         if (c == 12) start = 1'b0;
      end
      check("t5_dones", dn, 3);
      check("t5_rnd", rc, 4);
      check("t5_last_done", last_done, 12);
      check("t5_idle_gap", busy_c4, 0);
      @(negedge clk);
      @(negedge clk);
      check("t5_no_queue", busy, 0);
      check("t5_cnt", accept_cnt, 6);
      check("t5_parity", parity, 0);

      // saturation
      @(negedge clk);
      force dut.accept_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.accept_cnt;
      set_tot(100, 200, 150, 150);
      run(lat, rc);
      check("t6_lat", lat, 4);
      check("t6_cmd", command, 8'h66);
      check("t6_cnt", accept_cnt, 32'hFFFF_FFFF);
      post_run("t6", 1'b1);

      // exp boundary: x=-16 gives 3FFFFF
      set_tot(0, 116, 100, 0);
      r_exchange = 32'h003F_FFFF;
      run(lat, rc);
      check("t7_lat", lat, 3);
      check("t7_cmd", command, 0);
      post_run("t7", 1'b0);

      set_tot(116, 100, 7, 7);
      r_exchange = 32'h003F_FFFE;
      run(lat, rc);
      check("t8_lat", lat, 4);
      check("t8_cmd", command, 8'h66);
      check("t8_cnt", accept_cnt, 32'hFFFF_FFFF);
      post_run("t8", 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
